// File: rtl/ntt_job_scheduler_if.sv
// Signal bundle between ntt_job_scheduler and its environment:
// job commands, host BRAM port, wrapper BRAM/control and tagged completions.
interface ntt_job_scheduler_if #(
   parameter int TAG_W = 4
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic             cmd_mode;
   logic [TAG_W-1:0] cmd_tag;

   logic             host_en;
   logic             host_we;
   logic [7:0]       host_addr;
   logic [11:0]      host_din;
   logic [11:0]      host_dout;
   logic             host_grant;

   logic             bram_en;
   logic             bram_we;
   logic [7:0]       bram_addr;
   logic [11:0]      bram_din;
   logic [11:0]      bram_dout;

   logic             ntt_start;
   logic             ntt_mode;
   logic             ntt_done;

   logic             rsp_valid;
   logic [TAG_W-1:0] rsp_tag;
   logic             rsp_timeout;
   logic             busy;
   logic             irq;
   logic [1:0]       dbg_state;

   // Handshake: a command transfers on a clock edge where cmd_valid && cmd_ready;
   // rsp_valid is a single-cycle pulse with no back-pressure.

   // Scheduler side.
   modport slave (
      input  cmd_valid, cmd_mode, cmd_tag,
      input  host_en, host_we, host_addr, host_din,
      input  bram_dout, ntt_done,
      output cmd_ready, host_dout, host_grant,
      output bram_en, bram_we, bram_addr, bram_din,
      output ntt_start, ntt_mode,
      output rsp_valid, rsp_tag, rsp_timeout, busy, irq, dbg_state
   );

   // Host / wrapper side.
   modport master (
      output cmd_valid, cmd_mode, cmd_tag,
      output host_en, host_we, host_addr, host_din,
      output bram_dout, ntt_done,
      input  cmd_ready, host_dout, host_grant,
      input  bram_en, bram_we, bram_addr, bram_din,
      input  ntt_start, ntt_mode,
      input  rsp_valid, rsp_tag, rsp_timeout, busy, irq, dbg_state
   );
endinterface

// File: rtl/ntt_job_scheduler.sv
// Queues {mode, tag} NTT jobs, launches them on the NTT wrapper with a watchdog,
// and lends the wrapper's BRAM port to the host whenever no job is in flight.
module ntt_job_scheduler #(
   parameter int CMD_DEPTH      = 4,
   parameter int TAG_W          = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic               clk,
   input  logic               rst,
   ntt_job_scheduler_if.slave bus
);
   localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CMD_DEPTH);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t           state_q;
   state_t           state_d;

   logic [TAG_W:0]   fifo_mem [CMD_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_d;
   logic             ready_q;
   logic             fifo_empty;
   logic             push;
   logic             pop;

   logic             cur_mode;
   logic [TAG_W-1:0] cur_tag;
   logic [TMR_W-1:0] timer;
   logic [TAG_W-1:0] rsp_tag_q;
   logic             rsp_timeout_q;

   assign fifo_empty = (count == '0);
   assign push       = bus.cmd_valid && ready_q;
   // Host traffic wins: a pending job waits for a cycle with host_en low.
   assign pop        = (state_q == S_IDLE) && !fifo_empty && !bus.host_en;
   assign count_d    = count + CNT_W'(push) - CNT_W'(pop);

   assign bus.cmd_ready   = ready_q;
   assign bus.rsp_tag     = rsp_tag_q;
   assign bus.rsp_timeout = rsp_timeout_q;
   assign bus.busy        = (state_q != S_IDLE) || !fifo_empty;
   assign bus.dbg_state   = state_q;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= {bus.cmd_mode, bus.cmd_tag};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         ready_q       <= 1'b1;
         cur_mode      <= 1'b0;
         cur_tag       <= '0;
         timer         <= '0;
         rsp_tag_q     <= '0;
         rsp_timeout_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count   <= count_d;
         ready_q <= (count_d != FULL_CNT);
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr              <= rd_ptr + PTR_W'(1);
            {cur_mode, cur_tag} <= fifo_mem[rd_ptr];
         end
         if (state_q == S_ISSUE) begin
            timer <= '0;
         end else if (state_q == S_WAIT) begin
            timer <= timer + TMR_W'(1);
         end
         // A done arriving on the watchdog's last cycle still counts as success.
         if ((state_q == S_WAIT) && (state_d == S_RESP)) begin
            rsp_tag_q     <= cur_tag;
            rsp_timeout_q <= !bus.ntt_done;
         end
      end
   end

   always_comb begin
      state_d         = state_q;
      bus.ntt_start   = 1'b0;
      bus.ntt_mode    = 1'b0;
      bus.rsp_valid   = 1'b0;
      bus.irq         = 1'b0;
      bus.host_grant  = 1'b0;
      bus.bram_en     = 1'b0;
      bus.bram_we     = 1'b0;
      bus.bram_addr   = '0;
      bus.bram_din    = '0;
      bus.host_dout   = '0;
      case (state_q)
         S_IDLE: begin
            bus.host_grant = 1'b1;
            bus.bram_en    = bus.host_en;
            bus.bram_we    = bus.host_we;
            bus.bram_addr  = bus.host_addr;
            bus.bram_din   = bus.host_din;
            bus.host_dout  = bus.bram_dout;
            if (pop) begin
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            bus.ntt_start = 1'b1;
            bus.ntt_mode  = cur_mode;
            state_d       = S_WAIT;
         end
         S_WAIT: begin
            bus.ntt_mode = cur_mode;
            if (bus.ntt_done || (timer == TMR_LAST)) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            bus.ntt_mode  = cur_mode;
            bus.rsp_valid = 1'b1;
            bus.irq       = 1'b1;
            state_d       = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end
endmodule

// File: doc/ntt_job_scheduler.md
Name: ntt_job_scheduler

Overview:
Sequences NTT/INTT jobs on the NTT AXI wrapper and owns its BRAM port while the core runs. A small command FIFO takes {mode, tag} jobs. The scheduler pulses the wrapper's start/mode, waits for done with a timeout watchdog, and returns a tagged completion. The host BRAM port passes through to the wrapper only while no job is in flight.

Parameters:
CMD_DEPTH, 4, command FIFO entries (power of 2, >=2)
TAG_W, 4, job tag width
TIMEOUT_CYCLES, 4096, WAIT-state cycles before a job is declared timed out (>=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  job request
cmd_ready  out  1  FIFO not full
cmd_mode  in  1  0=NTT, 1=INTT
cmd_tag  in  TAG_W  job identifier
host_en  in  1  host BRAM enable
host_we  in  1  host BRAM write enable
host_addr  in  8  host coefficient address
host_din  in  12  host write data
host_dout  out  12  read data from wrapper
host_grant  out  1  host access currently routed
bram_en  out  1  to wrapper axi_bram_en
bram_we  out  1  to wrapper axi_bram_we
bram_addr  out  8  to wrapper axi_bram_addr
bram_din  out  12  to wrapper axi_bram_din
bram_dout  in  12  from wrapper axi_bram_dout
ntt_start  out  1  wrapper start pulse
ntt_mode  out  1  wrapper mode
ntt_done  in  1  wrapper done/irq
rsp_valid  out  1  one-cycle completion pulse
rsp_tag  out  TAG_W  tag of completed job
rsp_timeout  out  1  qualifies rsp_valid: 1=watchdog expired
busy  out  1  state != IDLE or FIFO non-empty
irq  out  1  equals rsp_valid

Behaviour:
- Reset: state=IDLE, FIFO empty, counters 0. All outputs 0 except cmd_ready=1 and host_grant=1. Reset mid-job aborts the job silently: no rsp pulse, FIFO flushed, ntt_start held 0.
- FIFO:
  - Push on cmd_valid&&cmd_ready.
  - cmd_ready=!full, registered. When full, no push occurs even if a pop happens in the same cycle.
  - Push and pop in the same non-full cycle both take effect. Occupancy is unchanged.
  - Pointers wrap modulo CMD_DEPTH.
- Host port:
  - host_grant=1 only in IDLE.
  - When granted, bram_* = host_* combinationally and host_dout=bram_dout. Read latency is the wrapper's (1 cycle).
  - When not granted, bram_en=bram_we=0. Host strobes are ignored, not queued.
- FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE:
  - IDLE: if FIFO non-empty and host_en=0, pop the head into cur_mode/cur_tag and go to ISSUE. Host has priority: while host_en=1, no job launches.
  - ISSUE (1 cycle): ntt_start=1, ntt_mode=cur_mode, timer cleared. Go to WAIT.
  - WAIT:
    - ntt_mode held at cur_mode; ntt_start=0; timer increments each cycle.
    - If ntt_done=1, go to RESP with timeout flag 0. This takes priority when it coincides with expiry.
    - Otherwise, if timer==TIMEOUT_CYCLES-1, go to RESP with flag 1.
  - RESP (1 cycle): rsp_valid=irq=1, rsp_tag=cur_tag, rsp_timeout=flag. Next state IDLE, where ntt_mode returns to 0.
- ntt_done seen outside WAIT is ignored.
- Back-to-back jobs: the minimum spacing between start pulses is done-latency+3 cycles.
- rsp_tag/rsp_timeout hold their values until the next RESP. They are valid only with rsp_valid.

Test Plan:
- Push {mode=0, tag=3} with FIFO empty and host idle: ntt_start high exactly 2 cycles after the push edge with ntt_mode=0. Model done 10 cycles later: rsp_valid 1 cycle later with tag=3, timeout=0, and irq identical to rsp_valid.
- Host writes 256 coefficients (2*i), then queue NTT tag1 and INTT tag2: two starts in order, with modes 0 then 1. Rsps arrive with tags 1 then 2. Host read-back returns 2*i.
- Push 5 commands back-to-back with DEPTH=4 while host_en=1: cmd_ready drops after the 4th and the 5th is not accepted. No ntt_start until host_en=0. Then exactly 4 jobs run in FIFO order.
- Never assert ntt_done with TIMEOUT_CYCLES=16: rsp_valid with rsp_timeout=1 arrives 17 cycles after start. The next queued job then starts normally.
- ntt_done coincident with the timer's final cycle: rsp_timeout=0. An ntt_done pulse while in IDLE produces no rsp.
- Host strobes during WAIT: bram_en=0 and host_grant=0. Assert rst mid-WAIT: the next cycle is IDLE, the FIFO is empty, no rsp occurs, and cmd_ready=1.
